// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: default MMIO
// addresses, status word bit positions and the transmit FSM state type.
package mmio_uart_tx_pkg;

  localparam logic [11:0] MMIO_TX_ADDR     = 12'hFFF;
  localparam logic [11:0] MMIO_STATUS_ADDR = 12'hFFE;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_FULL  = 1;
  localparam int unsigned STAT_EMPTY = 2;
  localparam int unsigned STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is accepted only when not full,
// judged on the count before any same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok = push && (count < CNT_FULL);
    pop_ok  = pop && (count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: stores to TX_ADDR queue a byte, a FIFO feeds an 8N1
// serialiser, and STATUS_ADDR exposes a registered status word.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [11:0] TX_ADDR      = MMIO_TX_ADDR,
  parameter logic [11:0] STATUS_ADDR  = MMIO_STATUS_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] status_q,
  output logic        status_hit,
  output logic        uart_tx,
  output logic        tx_busy,
  output logic        fifo_full,
  output logic        overflow
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;

  logic              tx_wr;
  logic              ctl_wr;
  logic              tx_wr_q;
  logic              ctl_wr_q;
  logic              tx_rise;
  logic              ctl_rise;
  logic              ovf_clr;
  logic              push_drop;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [31:0]       status_word;
  logic              unused_bits;

  // The processor runs at clock/4, so a store is seen for several cycles;
  // only the first cycle of each store acts.
  assign tx_wr     = wren && (address_dmem == TX_ADDR);
  assign ctl_wr    = wren && (address_dmem == STATUS_ADDR);
  assign tx_rise   = tx_wr && !tx_wr_q;
  assign ctl_rise  = ctl_wr && !ctl_wr_q;
  assign ovf_clr   = ctl_rise && data[0];
  assign push_drop = tx_rise && fifo_full;

  assign unused_bits = ^{data[31:8], fifo_count};

  always_comb begin
    fifo_pop = (state == IDLE) && !fifo_empty;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push    (tx_rise),
    .pop     (fifo_pop),
    .wr_data (data[7:0]),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A dropped push sets overflow even if a clear lands in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_q  <= 1'b0;
      ctl_wr_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_wr_q  <= tx_wr;
      ctl_wr_q <= ctl_wr;
      if (push_drop)    overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    status_word             = '0;
    status_word[STAT_BUSY]  = tx_busy;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_OVF]   = overflow;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_q   <= '0;
      status_hit <= 1'b0;
    end else begin
      status_q   <= status_word;
      status_hit <= (address_dmem == STATUS_ADDR);
    end
  end

  // uart_tx and tx_busy are assigned alongside each state change so the
  // line level always matches the state being entered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
          if (fifo_pop) begin
            shift_reg <= fifo_head;
            baud_cnt  <= '0;
            state     <= START;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              shift_reg <= shift_reg >> 1;
              uart_tx   <= shift_reg[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
